// File: rtl/note_sequencer.sv
// Song playback sequencer: fetches chord events from a synchronous ROM and
// holds each one on the packed notes bus for a programmed number of tempo ticks.
module note_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int TICK_DIV = 50000,
  parameter int DUR_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  input  logic                pause,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [28+DUR_W-1:0] rom_data,
  output logic [26:0]         notes,
  output logic                busy,
  output logic                event_strobe,
  output logic                done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_HOLD} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_tick_cnt, w_tick_nxt;
  logic [DUR_W-1:0]   r_remaining, w_rem_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic [26:0]        r_notes, w_notes_nxt;
  logic               r_strobe, w_strobe_nxt;
  logic               r_done, w_done_nxt;

  logic               w_end;
  logic [DUR_W-1:0]   w_dur;
  logic               w_tick_last;

  assign w_end       = rom_data[27+DUR_W];
  assign w_dur       = rom_data[27+DUR_W-1:27];
  assign w_tick_last = (r_tick_cnt == CNT_W'(TICK_DIV-1));

  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick_cnt;
    w_rem_nxt    = r_remaining;
    w_addr_nxt   = r_addr;
    w_notes_nxt  = r_notes;
    w_strobe_nxt = 1'b0;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_notes_nxt = '0;
        if (start) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = '0;
        end
      end
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_end) begin
          if (loop) begin
            w_addr_nxt  = '0;
            w_state_nxt = S_FETCH;
          end else begin
            w_notes_nxt = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_dur == '0) begin
          // zero-length events are skipped without touching the bus
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_state_nxt = S_FETCH;
        end else begin
          w_notes_nxt  = rom_data[26:0];
          w_rem_nxt    = w_dur;
          w_tick_nxt   = '0;
          w_addr_nxt   = r_addr + ADDR_W'(1);
          w_strobe_nxt = 1'b1;
          w_state_nxt  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!pause) begin
          if (w_tick_last) begin
            w_tick_nxt = '0;
            w_rem_nxt  = r_remaining - DUR_W'(1);
            if (r_remaining == DUR_W'(1)) w_state_nxt = S_FETCH;
          end else begin
            w_tick_nxt = r_tick_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // abort overrides whatever the active state decided
    if (stop && r_state != S_IDLE) begin
      w_state_nxt  = S_IDLE;
      w_notes_nxt  = '0;
      w_addr_nxt   = r_addr;
      w_tick_nxt   = '0;
      w_rem_nxt    = '0;
      w_strobe_nxt = 1'b0;
      w_done_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_remaining <= '0;
      r_addr      <= '0;
      r_notes     <= '0;
      r_strobe    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_tick_nxt;
      r_remaining <= w_rem_nxt;
      r_addr      <= w_addr_nxt;
      r_notes     <= w_notes_nxt;
      r_strobe    <= w_strobe_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign rom_addr     = r_addr;
  assign notes        = r_notes;
  assign busy         = (r_state != S_IDLE);
  assign event_strobe = r_strobe;
  assign done         = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed timing scenarios plus
// randomized songs/controls checked cycle by cycle against an event-level model.
module tb_note_sequencer;
  localparam int ADDR_W   = 3;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0, stop = 1'b0, loop = 1'b0, pause = 1'b0;
  logic [ADDR_W-1:0]   rom_addr;
  logic [28+DUR_W-1:0] rom_q;
  logic [26:0]         notes;
  logic                busy, event_strobe, done;

  logic [31:0] rom [DEPTH];

  note_sequencer #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop), .pause(pause),
    .rom_addr(rom_addr), .rom_data(rom_q), .notes(notes), .busy(busy),
    .event_strobe(event_strobe), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom[rom_addr];

  int n_chk = 0, n_err = 0;
  int cyc;
  int strobes[$];
  int dones[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] ev(input bit e, input int d, input logic [26:0] n);
    logic [3:0] dd;
    dd = d[3:0];
    return {e, dd, n};
  endfunction

  // Event-level model: a busy song either burns a number of unpaused hold
  // cycles, or spends two cycles fetching the next event from the song.
  bit          m_busy, m_strobe, m_done;
  int          m_addr, m_hold, m_fetch;
  logic [26:0] m_notes;

  task automatic model_step();
    logic [31:0] e;
    m_strobe = 0; m_done = 0;
    if (reset) begin
      m_busy = 0; m_addr = 0; m_notes = '0; m_hold = 0; m_fetch = 0;
    end else if (!m_busy) begin
      if (start) begin m_busy = 1; m_addr = 0; m_fetch = 2; end
    end else if (stop) begin
      m_busy = 0; m_notes = '0; m_hold = 0; m_fetch = 0;
    end else if (m_hold > 0) begin
      if (!pause) begin
        m_hold--;
        if (m_hold == 0) m_fetch = 2;
      end
    end else begin
      m_fetch--;
      if (m_fetch == 0) begin
        e = rom[m_addr];
        if (e[31]) begin
          if (loop) begin m_addr = 0; m_fetch = 2; end
          else begin m_busy = 0; m_notes = '0; m_done = 1; end
        end else if (e[30:27] == 0) begin
          m_addr = (m_addr + 1) % DEPTH; m_fetch = 2;
        end else begin
          m_notes  = e[26:0];
          m_hold   = int'(e[30:27]) * TICK_DIV;
          m_addr   = (m_addr + 1) % DEPTH;
          m_strobe = 1;
        end
      end
    end
  endtask

  task automatic tick_and_check();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    chk("notes", {5'd0, notes}, {5'd0, m_notes});
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("strobe", {31'd0, event_strobe}, {31'd0, m_strobe});
    chk("done", {31'd0, done}, {31'd0, m_done});
    if (event_strobe && done) chk("strobe_done_excl", 32'd1, 32'd0);
    if (event_strobe) strobes.push_back(cyc);
    if (done) dones.push_back(cyc);
  endtask

  task automatic do_reset();
    reset = 1; start = 0; stop = 0; pause = 0;
    tick_and_check();
    reset = 0;
    cyc = 0;
    strobes.delete();
    dones.delete();
  endtask

  // start pulsed into edge 1; optional pause window and stop edge
  task automatic run_seq(input int ncyc, input bit lp, input int pf, input int pl, input int stop_at);
    do_reset();
    loop = lp;
    for (int k = 1; k <= ncyc; k++) begin
      start = (k == 1);
      pause = (k >= pf && k < pf + pl);
      stop  = (k == stop_at);
      tick_and_check();
    end
    start = 0; pause = 0; stop = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = ev(1, 0, 0);

    // single event then end: strobe at 3, done at 3+2*4+2
    rom[0] = ev(0, 2, 27'h0000081); rom[1] = ev(1, 0, 0);
    run_seq(20, 0, 0, 0, 0);
    chk("t1_first_strobe", strobes.size() > 0 ? strobes[0] : -1, 3);
    chk("t1_done_cyc", dones.size() > 0 ? dones[0] : -1, 13);
    chk("t1_idle_after", {31'd0, busy}, 32'd0);

    // looping: event visible 8+2 cycles, then end marker fetch adds 2
    run_seq(40, 1, 0, 0, 0);
    chk("t2_period", strobes.size() > 1 ? strobes[1] - strobes[0] : -1, 12);
    chk("t2_no_done", dones.size(), 0);

    // zero-duration event skipped
    rom[0] = ev(0, 0, 27'h1234567); rom[1] = ev(0, 1, 27'h4020100); rom[2] = ev(1, 0, 0);
    run_seq(15, 0, 0, 0, 0);
    chk("t3_strobe_cyc", strobes.size() > 0 ? strobes[0] : -1, 5);
    chk("t3_one_strobe", strobes.size(), 1);

    // pause of 10 cycles inside a dur=3 hold extends it by exactly 10
    rom[0] = ev(0, 3, 27'h2AAAAAA); rom[1] = ev(1, 0, 0);
    run_seq(35, 0, 5, 10, 0);
    chk("t4_done_cyc", dones.size() > 0 ? dones[0] : -1, 27);

    // stop in HOLD, then stop in FETCH
    run_seq(10, 0, 0, 0, 6);
    chk("t5_stop_hold_busy", {31'd0, busy}, 32'd0);
    chk("t5_stop_hold_done", dones.size(), 0);
    run_seq(10, 0, 0, 0, 2);
    chk("t5_stop_fetch_strobes", strobes.size(), 0);

    // address wrap with all dur=1 events; strobes every TICK_DIV+2
    for (int i = 0; i < DEPTH; i++) rom[i] = ev(0, 1, 27'(i * 27'h10101 + 1));
    run_seq(70, 0, 0, 0, 0);
    chk("t6_period", strobes.size() > 1 ? strobes[1] - strobes[0] : -1, TICK_DIV + 2);
    chk("t6_wrapped", strobes.size() > DEPTH ? 1 : 0, 1);
    reset = 1;
    tick_and_check();
    reset = 0;
    chk("t6_reset_notes", {5'd0, notes}, 32'd0);

    // randomized songs and controls
    for (int t = 0; t < 30; t++) begin
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
        bit e;
        e = (t % 4 != 0) && ($urandom_range(0, 7) == 0);
        rom[i] = ev(e, $urandom_range(0, 3), 27'($urandom));
      end
      loop = $urandom_range(0, 1);
      for (int k = 0; k < 150; k++) begin
        start = ($urandom_range(0, 9) == 0);
        stop  = ($urandom_range(0, 39) == 0);
        pause = ($urandom_range(0, 3) == 0);
        reset = ($urandom_range(0, 199) == 0);
        tick_and_check();
      end
      reset = 0;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
